// File: rtl/instruction_set.sv
// ============================================================================
// Module : instruction_set (package)
// Desc   : Shared memory-op and arbiter-state types.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instruction_set;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } MEM_OPS_T;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ARB_STATE_T;

  // The wait counter must hold MEM_LAT-1 for latencies up to 7.
  localparam int unsigned LAT_CNT_W = 3;

  function automatic logic op_valid(input MEM_OPS_T op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Desc   : Two-port round-robin memory arbiter, fixed access latency.
//          Optional grant counters with macro MEM_ARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import instruction_set::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  MEM_OPS_T          p0_op,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  MEM_OPS_T          p1_op,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_done,
  output logic              p1_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output MEM_OPS_T          mem_op,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);

  localparam logic [LAT_CNT_W-1:0] c_lat_init = LAT_CNT_W'(MEM_LAT - 1);

  ARB_STATE_T             state_q, state_d;
  logic                   win_q, win_d;           // 1 = port 1 owns the transaction
  logic                   last_gnt_q, last_gnt_d;
  MEM_OPS_T               op_q, op_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata0_q, rdata0_d;
  logic [DATA_W-1:0]      rdata1_q, rdata1_d;
  logic                   elig0, elig1, pick;
  logic [DATA_W-1:0]      rd_val;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_gnt_d = last_gnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rd_val     = '0;

    elig0 = p0_req && op_valid(p0_op);
    elig1 = p1_req && op_valid(p1_op);
    // On a tie the port that was not served last wins.
    pick  = (elig0 && elig1) ? ~last_gnt_q : elig1;

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          win_d   = pick;
          op_d    = pick ? p1_op    : p0_op;
          addr_d  = pick ? p1_addr  : p0_addr;
          wdata_d = pick ? p1_wdata : p0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = c_lat_init;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rd_val = (op_q == MEM_READ) ? mem_rdata : '0;
          if (win_q) rdata1_d = rd_val;
          else       rdata0_d = rd_val;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        last_gnt_d = win_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      op_q       <= MEM_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_gnt_q <= last_gnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign mem_op    = (state_q == ISSUE) ? op_q    : MEM_NOP;
  assign mem_addr  = (state_q == ISSUE) ? addr_q  : '0;
  assign mem_wdata = (state_q == ISSUE) ? wdata_q : '0;
  assign p0_gnt    = (state_q == ISSUE) && !win_q;
  assign p1_gnt    = (state_q == ISSUE) &&  win_q;
  assign p0_done   = (state_q == DONE)  && !win_q;
  assign p1_done   = (state_q == DONE)  &&  win_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (p0_gnt && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (p1_gnt && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Desc   : Self-checking bench for mem_arbiter (vector table + done scoreboard).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import instruction_set::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int MEM_LAT = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              p0_req, p1_req;
  MEM_OPS_T          p0_op, p1_op;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt, p1_gnt, p0_done, p1_done;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  MEM_OPS_T          mem_op;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]       gnt_cnt0, gnt_cnt1;
`endif

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_op(p0_op), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_op(p1_op), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_op(mem_op), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: unwritten locations read as addr[7:0]^8'hB5; off-cycle data is 8'hEE.
  logic       mem_clr;
  logic [7:0] mem_arr  [0:255];
  logic       wr_valid [0:255];
  logic [7:0] idx;
  assign idx = mem_addr[11:4];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) wr_valid[i] <= 1'b0;
    end else if (mem_op == MEM_WRITE) begin
      mem_arr[idx]  <= mem_wdata;
      wr_valid[idx] <= 1'b1;
    end
    if (mem_op == MEM_READ)
      mem_rdata <= wr_valid[idx] ? mem_arr[idx] : (mem_addr[7:0] ^ 8'hB5);
    else
      mem_rdata <= 8'hEE;
  end

  typedef struct {
    logic      port;
    MEM_OPS_T  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;
  int          cmd_cnt;
  MEM_OPS_T    cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        sb_port[$];
  logic [7:0]  sb_data[$];
  logic [7:0]  model_rd[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic p;
    logic [7:0] d;
    @(negedge clk);
    check("gnt mutex", {31'd0, p0_gnt && p1_gnt}, 0);
    check("done mutex", {31'd0, p0_done && p1_done}, 0);
    if (mem_op != MEM_NOP) begin
      cmd_cnt++;
      cmd_op    = mem_op;
      cmd_addr  = mem_addr;
      cmd_wdata = mem_wdata;
    end
    if (p0_done || p1_done) begin
      if (sb_port.size() == 0) begin
        check("unexpected done", 1, 0);
      end else begin
        p = sb_port.pop_front();
        d = sb_data.pop_front();
        check("done port", {31'd0, p1_done}, {31'd0, p});
        check("done rdata", {24'd0, (p1_done ? p1_rdata : p0_rdata)}, {24'd0, d});
      end
    end
  endtask

  task automatic drive(input logic port, input logic req, input MEM_OPS_T op,
                       input logic [15:0] addr, input logic [7:0] wd);
    if (port) begin
      p1_req = req; p1_op = op; p1_addr = addr; p1_wdata = wd;
    end else begin
      p0_req = req; p0_op = op; p0_addr = addr; p0_wdata = wd;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_rd[0] = 8'h00;
    model_rd[1] = 8'h00;
  endtask

  task automatic do_txn(input string nm, input vec_t v);
    int gnt_at, done_at;
    gnt_at  = -1;
    done_at = -1;
    cmd_cnt = 0;
    sb_port.push_back(v.port);
    sb_data.push_back(v.exp_rd);
    drive(v.port, 1'b1, v.op, v.addr, v.wdata);
    for (int n = 1; n <= 16 && done_at < 0; n++) begin
      tick();
      if (gnt_at < 0 && (v.port ? p1_gnt : p0_gnt)) begin
        gnt_at = n;
        drive(v.port, 1'b0, MEM_NOP, 16'h0, 8'h0);
      end
      if (v.port ? p1_done : p0_done) done_at = n;
    end
    drive(v.port, 1'b0, MEM_NOP, 16'h0, 8'h0);
    check({nm, " gnt latency"}, gnt_at, 1);
    check({nm, " done latency"}, done_at, 2 + MEM_LAT);
    check({nm, " cmd cycles"}, cmd_cnt, 1);
    check({nm, " cmd op"}, {30'd0, cmd_op}, {30'd0, v.op});
    check({nm, " cmd addr"}, {16'd0, cmd_addr}, {16'd0, v.addr});
    if (v.op == MEM_WRITE) check({nm, " cmd wdata"}, {24'd0, cmd_wdata}, {24'd0, v.wdata});
    model_rd[v.port] = v.exp_rd;
    check({nm, " p0_rdata"}, {24'd0, p0_rdata}, {24'd0, model_rd[0]});
    check({nm, " p1_rdata"}, {24'd0, p1_rdata}, {24'd0, model_rd[1]});
    tick();
  endtask

  // Both ports request in one cycle; p0 expected first (last_gnt points to p1).
  task automatic do_pair(input string nm, input vec_t v0, input vec_t v1);
    int g0, g1, d0, d1;
    g0 = -1; g1 = -1; d0 = -1; d1 = -1;
    sb_port.push_back(1'b0); sb_data.push_back(v0.exp_rd);
    sb_port.push_back(1'b1); sb_data.push_back(v1.exp_rd);
    drive(1'b0, 1'b1, v0.op, v0.addr, v0.wdata);
    drive(1'b1, 1'b1, v1.op, v1.addr, v1.wdata);
    for (int n = 1; n <= 24 && d1 < 0; n++) begin
      tick();
      if (g0 < 0 && p0_gnt) begin g0 = n; drive(1'b0, 1'b0, MEM_NOP, 16'h0, 8'h0); end
      if (g1 < 0 && p1_gnt) begin g1 = n; drive(1'b1, 1'b0, MEM_NOP, 16'h0, 8'h0); end
      if (p0_done) d0 = n;
      if (p1_done) d1 = n;
    end
    drive(1'b0, 1'b0, MEM_NOP, 16'h0, 8'h0);
    drive(1'b1, 1'b0, MEM_NOP, 16'h0, 8'h0);
    check({nm, " p0 gnt"}, g0, 1);
    check({nm, " p0 done"}, d0, 2 + MEM_LAT);
    check({nm, " p1 gnt"}, g1, 4 + MEM_LAT);
    check({nm, " p1 done"}, d1, 5 + 2 * MEM_LAT);
    model_rd[0] = v0.exp_rd;
    model_rd[1] = v1.exp_rd;
    check({nm, " p0_rdata held"}, {24'd0, p0_rdata}, {24'd0, model_rd[0]});
    tick();
  endtask

  initial begin
    int gseen;
    vec_t rr0, rr1;
    reset   = 1'b1;
    mem_clr = 1'b1;
    drive(1'b0, 1'b0, MEM_NOP, 16'h0, 8'h0);
    drive(1'b1, 1'b0, MEM_NOP, 16'h0, 8'h0);
    cmd_cnt = 0;

    vecs[0] = '{1'b0, MEM_READ,  16'h0010, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, MEM_WRITE, 16'h0200, 8'h3C, 8'h00};
    vecs[2] = '{1'b0, MEM_READ,  16'h0200, 8'h00, 8'h3C};
    vecs[3] = '{1'b1, MEM_READ,  16'h0010, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, MEM_WRITE, 16'h0033, 8'h5A, 8'h00};
    vecs[5] = '{1'b1, MEM_READ,  16'h0033, 8'h00, 8'h5A};
    vecs[6] = '{1'b0, MEM_READ,  16'h0044, 8'h00, 8'hF1};

    apply_reset();
    mem_clr = 1'b0;
    check("reset gnt",   {30'd0, p0_gnt, p1_gnt}, 0);
    check("reset done",  {30'd0, p0_done, p1_done}, 0);
    check("reset rdata", {16'd0, p0_rdata, p1_rdata}, 0);
    check("reset mem_op", {30'd0, mem_op}, {30'd0, MEM_NOP});
    check("reset mem_addr/wdata", {8'd0, mem_addr, mem_wdata}, 0);

    for (int i = 0; i < 7; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

    // Round-robin: two simultaneous pairs after reset, p0 first both times.
    apply_reset();
    rr0 = '{1'b0, MEM_READ, 16'h0010, 8'h00, 8'hA5};
    rr1 = '{1'b1, MEM_READ, 16'h0033, 8'h00, 8'h5A};
    do_pair("rr1", rr0, rr1);
    rr0 = '{1'b0, MEM_READ,  16'h0200, 8'h00, 8'h3C};
    rr1 = '{1'b1, MEM_WRITE, 16'h0300, 8'h11, 8'h00};
    do_pair("rr2", rr0, rr1);

    // NOP request must be ignored.
    cmd_cnt = 0;
    gseen   = 0;
    drive(1'b0, 1'b1, MEM_NOP, 16'h1234, 8'h99);
    for (int n = 0; n < 6; n++) begin
      tick();
      if (p0_gnt || p1_gnt) gseen++;
    end
    drive(1'b0, 1'b0, MEM_NOP, 16'h0, 8'h0);
    check("nop gnt count", gseen, 0);
    check("nop cmd count", cmd_cnt, 0);
    do_txn("after nop", '{1'b0, MEM_READ, 16'h0300, 8'h00, 8'h11});

    // Reset during WAIT: transaction dropped silently.
    drive(1'b0, 1'b1, MEM_READ, 16'h0010, 8'h00);
    tick();
    check("rst-wait gnt", {31'd0, p0_gnt}, 1);
    drive(1'b0, 1'b0, MEM_NOP, 16'h0, 8'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_rd[0] = 8'h00;
    model_rd[1] = 8'h00;
    check("rst-wait done", {30'd0, p0_done, p1_done}, 0);
    check("rst-wait mem_op", {30'd0, mem_op}, {30'd0, MEM_NOP});
    check("rst-wait rdata", {16'd0, p0_rdata, p1_rdata}, 0);
    for (int n = 0; n < 4; n++) tick();
    do_txn("post-rst p1", '{1'b1, MEM_READ, 16'h0300, 8'h00, 8'h11});

`ifdef MEM_ARB_STATS_EN
    apply_reset();
    for (int i = 0; i < 3; i++)
      do_txn($sformatf("stat%0d", i), '{1'b1, MEM_READ, 16'h0010, 8'h00, 8'hA5});
    check("gnt_cnt1", {16'd0, gnt_cnt1}, 3);
    check("gnt_cnt0", {16'd0, gnt_cnt0}, 0);
`endif

    check("scoreboard empty", sb_port.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, which is the memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, which is the memory data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, which is the memory read latency in cycles (range 1..7).
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports p0_req / p1_req, input, 1 bit each: access request from port 0 (core) and port 1 (loader/debug).
REQ-007 SHALL have ports p0_op / p1_op, input, MEM_OPS_T: requested operation, MEM_READ or MEM_WRITE.
REQ-008 SHALL have ports p0_addr / p1_addr, input, ADDR_W: request address.
REQ-009 SHALL have ports p0_wdata / p1_wdata, input, DATA_W: write data.
REQ-010 SHALL have ports p0_gnt / p1_gnt, output, 1 bit: grant pulse.
REQ-011 SHALL have ports p0_done / p1_done, output, 1 bit: completion pulse.
REQ-012 SHALL have ports p0_rdata / p1_rdata, output, DATA_W: read data, valid while done is high.
REQ-013 SHALL have ports mem_addr (output, ADDR_W), mem_op (output, MEM_OPS_T) and mem_wdata (output, DATA_W): memory command.
REQ-014 SHALL have port mem_rdata, input, DATA_W: memory read data, valid MEM_LAT cycles after the MEM_READ cycle.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-016 SHALL treat a port as eligible in IDLE only if its req=1 and its op is MEM_READ or MEM_WRITE; a request with op MEM_NOP SHALL be ignored.
REQ-017 SHALL, in IDLE with one eligible port, latch that port's op, addr and wdata and go to ISSUE next cycle.
REQ-018 SHALL, when both ports are eligible in the same cycle, grant the port not served last (round-robin pointer last_gnt).
REQ-019 SHALL, in ISSUE, drive mem_op, mem_addr and mem_wdata from the latched values for exactly one cycle, pulse the winner's gnt for that cycle, and go to WAIT.
REQ-020 SHALL, in WAIT, drive mem_op=MEM_NOP, count MEM_LAT cycles (the count applies to writes as well), capture mem_rdata on the final WAIT cycle for reads, and then go to DONE.
REQ-021 SHALL, in DONE, pulse the winner's done for one cycle with rdata held, update last_gnt, and return to IDLE.
REQ-022 SHALL give a fixed access latency: request sampled in IDLE at edge t, gnt at cycle t+1, done at cycle t+2+MEM_LAT.
REQ-023 SHALL hold rdata outputs stable between dones, and SHALL give rdata the value 0 after a write completion.
REQ-024 SHALL not sample new requests in ISSUE, WAIT or DONE; the requester holds req until its gnt.
REQ-025 SHALL treat a req still high in the IDLE cycle after done as a new request.
REQ-026 SHALL never assert both gnt outputs, or both done outputs, in the same cycle.

Reset
REQ-027 SHALL, on reset, force state=IDLE, last_gnt=1 (port 0 wins the first tie), all gnt/done outputs=0, all rdata outputs=0, mem_op=MEM_NOP, mem_addr=0 and mem_wdata=0.
REQ-028 SHALL, on reset asserted mid-transaction, abandon the transaction with no done pulse, and SHALL produce no memory command in the cycle after reset.

Configuration
REQ-029 SHALL, with macro MEM_ARB_STATS_EN defined, add output ports gnt_cnt0 and gnt_cnt1 (16 bits each), which increment on the respective gnt pulse, saturate at 16'hFFFF and reset to 0.
REQ-030 SHALL, without MEM_ARB_STATS_EN, have neither these ports nor their counter logic.

Structure
REQ-031 SHALL place MEM_OPS_T in the shared instruction_set package.
REQ-032 SHALL place the new ARB_STATE_T enum (IDLE, ISSUE, WAIT, DONE) in the shared instruction_set package.
REQ-033 SHALL be a single module with no sub-modules; the round-robin pick SHALL be combinational logic inside it.

Verification
REQ-034 SHALL verify: p0 read addr 16'h0010 with MEM_LAT=1 and memory returning 8'hA5 -> mem_op=MEM_READ one cycle, p0_gnt at t+1, p0_done at t+3 with p0_rdata=8'hA5.
REQ-035 SHALL verify: p0 and p1 requesting in the same cycle after reset -> p0 served first, then p1, with no gap beyond one IDLE cycle; a second simultaneous pair -> p0 served first again.
REQ-036 SHALL verify: p1 write of 8'h3C to 16'h0200 -> exactly one MEM_WRITE cycle with mem_addr=16'h0200 and mem_wdata=8'h3C, p1_done pulsed, p1_rdata=0.
REQ-037 SHALL verify: p0 request with op MEM_NOP -> no gnt, no memory command, FSM stays IDLE.
REQ-038 SHALL verify: reset asserted during WAIT -> no done, mem_op=MEM_NOP, IDLE next cycle, and a subsequent p1 request granted normally.
REQ-039 SHALL verify: with MEM_ARB_STATS_EN defined, three p1 grants -> gnt_cnt1=3 and gnt_cnt0=0.
